// File: rtl/ar_geom_pkg.sv
// ---------------------------------------------------------------------------
// ar_geom_pkg
// Shared geometry constants for the xy_to_theta angle search.
//   RADIUS     : magnitude of the reference diamond (|x|+|y| = 48)
//   STEP_DEG   : angular resolution of the search, in degrees
//   NUM_STEPS  : number of candidate angles (0..350 in STEP_DEG steps)
//   Y_TABLE    : first-quadrant |y| values for 0..90 degrees
//   state_t    : search FSM states
// ---------------------------------------------------------------------------
package ar_geom_pkg;

    localparam int RADIUS    = 48;
    localparam int STEP_DEG  = 10;
    localparam int NUM_STEPS = 36;

    localparam logic signed [6:0] Y_TABLE [0:9] = '{
        7'sd0,  7'sd5,  7'sd10, 7'sd16, 7'sd21,
        7'sd26, 7'sd32, 7'sd37, 7'sd43, 7'sd48
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Step index to angle in degrees (max 35*10 = 350, fits 9 bits).
    function automatic logic [8:0] step_to_angle(input logic [5:0] s);
        return 9'(s) * 9'(STEP_DEG);
    endfunction

endpackage

// File: rtl/angle_lut.sv
// ---------------------------------------------------------------------------
// angle_lut
// Combinational forward mapping from a 10-degree step index to the point on
// the reference diamond used as the match candidate for that angle.
// Ports:
//   step  in   6  step index 0..35 (values above 35 return (0,0))
//   x_k   out  7  signed candidate x
//   y_k   out  7  signed candidate y
// ---------------------------------------------------------------------------
module angle_lut
    import ar_geom_pkg::*;
(
    input  logic [5:0]        step,
    output logic signed [6:0] x_k,
    output logic signed [6:0] y_k
);

    localparam logic signed [6:0] R7 = 7'(RADIUS);

    logic [3:0]        idx;
    logic signed [6:0] mag;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        idx = 4'd0;
        mag = 7'sd0;
        x_k = 7'sd0;
        y_k = 7'sd0;
        if (step <= 6'd9) begin
            // 0..90: y rises along Y_TABLE, x shrinks toward 0
            idx = step[3:0];
            mag = Y_TABLE[idx];
            y_k = mag;
            x_k = R7 - mag;
        end else if (step <= 6'd18) begin
            // 100..180: table read backwards, x negative
            idx = 4'(6'd18 - step);
            mag = Y_TABLE[idx];
            y_k = mag;
            x_k = mag - R7;
        end else if (step <= 6'd27) begin
            // 190..270: y negative; 270 lands on (0,-48)
            idx = 4'(step - 6'd18);
            mag = Y_TABLE[idx];
            y_k = -mag;
            x_k = -R7 + mag;
        end else if (step <= 6'd35) begin
            // 280..350: table read backwards, y negative, x positive
            idx = 4'(6'd36 - step);
            mag = Y_TABLE[idx];
            y_k = -mag;
            x_k = R7 - mag;
        end
    end

endmodule

// File: rtl/xy_to_theta.sv
// ---------------------------------------------------------------------------
// xy_to_theta
// Finds the 10-degree angle whose reference point is closest (L1 distance)
// to a card-frame (x,y) sample, by sequentially scoring all 36 candidates.
// Fixed latency: valid_out is high on the 37th rising edge after accept.
// Ports:
//   clk_in     in   1  clock, rising edge
//   rst_in     in   1  synchronous active-high reset
//   x_in       in   7  signed x, sampled on accept
//   y_in       in   7  signed y, sampled on accept
//   valid_in   in   1  request strobe (accepted when ready_out is high)
//   ready_out  out  1  high only while idle
//   angle_out  out  9  best-match angle, held until the next result
//   valid_out  out  1  one-cycle result strobe
//   err_out    out  8  best L1 error (only with XY_TO_THETA_ERR_EN defined)
// Build option: define XY_TO_THETA_ERR_EN to add the err_out port/register.
// ---------------------------------------------------------------------------
module xy_to_theta
    import ar_geom_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic signed [6:0] x_in,
    input  logic signed [6:0] y_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [8:0]        angle_out,
    output logic              valid_out
`ifdef XY_TO_THETA_ERR_EN
    ,
    output logic [7:0]        err_out
`endif
);

    localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

    state_t            state;
    logic signed [6:0] x_r;
    logic signed [6:0] y_r;
    logic [5:0]        step;
    logic [7:0]        best_err;
    logic [5:0]        best_step;

    logic signed [6:0] x_k;
    logic signed [6:0] y_k;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [7:0]        ax;
    logic [7:0]        ay;
    logic [7:0]        err_k;
    logic              better;

    angle_lut u_lut (
        .step (step),
        .x_k  (x_k),
        .y_k  (y_k)
    );

    // Each |difference| is at most 64+48 = 112, so the sum (<= 224) fits
    // 8 bits unsigned without wrap.
    always_comb begin
        dx     = {{2{x_r[6]}}, x_r} - {{2{x_k[6]}}, x_k};
        dy     = {{2{y_r[6]}}, y_r} - {{2{y_k[6]}}, y_k};
        ax     = dx[8] ? 8'(-dx) : dx[7:0];
        ay     = dy[8] ? 8'(-dy) : dy[7:0];
        err_k  = ax + ay;
        // Strict compare: an equal error never displaces an earlier angle.
        better = (err_k < best_err);
    end

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
            angle_out <= '0;
            x_r       <= '0;
            y_r       <= '0;
            step      <= '0;
            best_err  <= '0;
            best_step <= '0;
`ifdef XY_TO_THETA_ERR_EN
            err_out   <= '0;
`endif
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in && ready_out) begin
                        x_r       <= x_in;
                        y_r       <= y_in;
                        step      <= '0;
                        best_err  <= 8'hFF;   // above any reachable error
                        best_step <= '0;
                        ready_out <= 1'b0;
                        state     <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (better) begin
                        best_err  <= err_k;
                        best_step <= step;
                    end
                    if (step == LAST_STEP) begin
                        // Fold the last candidate in directly so the result
                        // and its strobe leave together on entry to DONE.
                        state     <= DONE;
                        valid_out <= 1'b1;
                        angle_out <= step_to_angle(better ? step : best_step);
`ifdef XY_TO_THETA_ERR_EN
                        err_out   <= better ? err_k : best_err;
`endif
                    end else begin
                        step <= step + 6'd1;
                    end
                end

                DONE: begin
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xy_to_theta.sv
// ---------------------------------------------------------------------------
// tb_xy_to_theta
// Directed vectors with hand-computed angle/error. A stimulus process issues
// requests and queues the expected result; a monitor pops and compares on
// every valid_out pulse, also checking latency and pulse width.
// ---------------------------------------------------------------------------
module tb_xy_to_theta;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic signed [6:0] x_in;
    logic signed [6:0] y_in;
    logic              valid_in;
    logic              ready_out;
    logic [8:0]        angle_out;
    logic              valid_out;
`ifdef XY_TO_THETA_ERR_EN
    logic [7:0]        err_out;
`endif

    xy_to_theta dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .angle_out (angle_out),
        .valid_out (valid_out)
`ifdef XY_TO_THETA_ERR_EN
        ,
        .err_out   (err_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int edge_cnt = 0;
    always @(posedge clk_in) edge_cnt = edge_cnt + 1;

    typedef struct {
        int angle;
        int err;
        int acc_edge;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: sampled on the falling edge. A result set up by edge N is seen
    // here with edge_cnt == N; valid_out is high at edge 37 after accept when
    // it was set by edge 36, i.e. seen here with edge_cnt - acc_edge == 36.
    bit chk_low = 1'b0;
    always @(negedge clk_in) begin
        if (chk_low) begin
            check("valid_out_one_cycle", int'(valid_out), 0);
            chk_low = 1'b0;
        end else if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_valid_out");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("angle_out", int'(angle_out), e.angle);
                check("latency", edge_cnt - e.acc_edge, 36);
`ifdef XY_TO_THETA_ERR_EN
                check("err_out", int'(err_out), e.err);
`endif
                chk_low = 1'b1;
            end
        end
    end

    // Issue one request. With now=1 the caller is already at a falling edge.
    task automatic send(input int x, input int y, input int ang, input int er,
                        input bit now = 1'b0);
        int waited = 0;
        if (!now) @(negedge clk_in);
        while (ready_out !== 1'b1 && waited < 300) begin
            @(negedge clk_in);
            waited++;
        end
        if (ready_out !== 1'b1) begin
            fail_now("ready_out_timeout");
            return;
        end
        x_in     = 7'(x);
        y_in     = 7'(y);
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sb.push_back('{ang, er, edge_cnt});
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((sb.size() != 0 || ready_out !== 1'b1) && waited < 500) begin
            @(negedge clk_in);
            waited++;
        end
        if (sb.size() != 0) begin
            fail_now("result_timeout");
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        x_in     = '0;
        y_in     = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Reset state
        check("reset_ready_out", int'(ready_out), 1);
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_angle_out", int'(angle_out), 0);
`ifdef XY_TO_THETA_ERR_EN
        check("reset_err_out", int'(err_out), 0);
`endif

        // Exact points on the diamond
        send(48, 0, 0, 0);
        wait_drain();
        send(0, 48, 90, 0);
        wait_drain();
        // Back-to-back: each waits only for ready_out
        send(-48, 0, 180, 0);
        send(0, -48, 270, 0);
        send(43, 5, 10, 0);
        send(5, -43, 280, 0);
        wait_drain();
        // Off-diamond points (hand-scored over all 36 candidates)
        send(-37, -11, 200, 2);   // 190 scores 12, 200 scores 1+1
        send(20, 20, 40, 8);      // 40 and 50 tie at 8 -> lower angle
        send(0, 0, 0, 48);        // every candidate scores 48
        send(-64, -64, 180, 80);  // 180..270 tie at 80
        send(63, 63, 0, 78);      // 0..90 tie at 78
        send(-64, 63, 90, 79);    // 90..180 tie at 79
        wait_drain();

        // valid_in during SEARCH is dropped
        send(0, -48, 270, 0);
        repeat (5) @(negedge clk_in);
        check("ready_low_in_search", int'(ready_out), 0);
        x_in     = 7'(-20);
        y_in     = 7'(30);
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        wait_drain();
        repeat (45) @(negedge clk_in);   // any stray second result shows up here

        // Reset during SEARCH aborts; a new request is taken right after
        @(negedge clk_in);
        x_in     = 7'(43);
        y_in     = 7'(5);
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (19) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("abort_ready_out", int'(ready_out), 1);
        check("abort_valid_out", int'(valid_out), 0);
        check("abort_angle_out", int'(angle_out), 0);
        send(-48, 0, 180, 0, 1'b1);
        wait_drain();
        repeat (45) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
